mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The clock port SHALL be: clk  input  1  rising-edge clock.
REQ-003 The reset port SHALL be: reset  input  1  synchronous active-high reset.
REQ-004 The port start SHALL be: input  1  issue strobe from the E stage, sampled at the rising clk edge.
REQ-005 The port mdop SHALL be: input  4  operation code; encodings are defined in mdu_pkg.
REQ-006 The port srcA SHALL be: input  32  operand A (rs value).
REQ-007 The port srcB SHALL be: input  32  operand B (rt value).
REQ-008 The port rd_hi SHALL be: input  1  read select (1 = HI, 0 = LO).
REQ-009 The port busy SHALL be: output  1  registered; high while a multiply or divide is in flight; feeds the hazard unit busy input.
REQ-010 The port hi SHALL be: output  32  architectural HI register.
REQ-011 The port lo SHALL be: output  32  architectural LO register.
REQ-012 The port rdata SHALL be: output  32  combinational value, hi when rd_hi = 1, else lo.

Function
REQ-013 The FSM SHALL have three states: IDLE, MUL, DIV.
REQ-014 In IDLE, start with MULT/MULTU (or a MADD-class op, see Configuration) SHALL latch the product into a pending register, load cnt = 5 and go to MUL.
REQ-015 In IDLE, start with DIV/DIVU SHALL latch the quotient and remainder into a pending register, load cnt = 10 and go to DIV.
REQ-016 busy SHALL be 1 from the cycle after the start edge through exactly 5 cycles (MUL) or 10 cycles (DIV).
REQ-017 On the edge that ends the last busy cycle, the FSM SHALL commit the pending result to HI/LO and return to IDLE; busy SHALL be 0 in the following cycle.
REQ-018 HI/LO SHALL hold their previous values for the whole busy window.
REQ-019 MULT SHALL produce the signed 64-bit product with {hi,lo} = product; MULTU SHALL do the same unsigned.
REQ-020 DIV SHALL truncate toward zero, with lo = quotient and hi = remainder (remainder takes the sign of the dividend).
REQ-021 DIVU SHALL produce the unsigned quotient and remainder in the same lo/hi positions.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-023 Divide by zero SHALL still run the full 10 busy cycles, and HI/LO SHALL be left unchanged at commit.
REQ-024 MTHI/MTLO in IDLE SHALL write srcA into hi/lo at the start edge, with no busy cycle.
REQ-025 start while busy = 1 SHALL be ignored entirely: no state change, no HI/LO write, cnt not reloaded.
REQ-026 start with an undefined mdop in IDLE SHALL be a no-op.
REQ-027 cnt SHALL be 4 bits wide, decrement once per cycle in MUL/DIV, and never wrap below 0.
REQ-028 Back-to-back use SHALL be supported: a start in the first cycle with busy = 0 after a commit SHALL be accepted.

Reset
REQ-029 When reset is sampled high, the block SHALL go to state IDLE with busy = 0, hi = 0, lo = 0, cnt = 0 and the pending register cleared.
REQ-030 Reset asserted mid-operation SHALL discard the in-flight result, with no commit to HI/LO.
REQ-031 Reset SHALL take priority over a simultaneous start.

Configuration
REQ-032 With macro MDU_MADD_EN defined, the ops MADD, MADDU, MSUB and MSUBU SHALL be accepted.
REQ-033 Each MADD-class op SHALL compute {hi,lo} ± srcA*srcB (signed or unsigned), sampling {hi,lo} at the start edge, and use the MUL state with 5-cycle latency.
REQ-034 Without MDU_MADD_EN, those encodings SHALL be treated as undefined (no-op) and the accumulate datapath SHALL be absent.

Structure
REQ-035 Package mdu_pkg SHALL hold: the mdop encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9), the constants MUL_LAT=5 and DIV_LAT=10, and the FSM state typedef.
REQ-036 There SHALL be one sub-module, mdu_arith: combinational 64-bit product/accumulate and signed/unsigned quotient/remainder, with a div-by-zero flag output.
REQ-037 mdu_ctrl SHALL contain the FSM, the counter, the pending register and the HI/LO registers.

Verification
REQ-038 The bench SHALL cover MULT: srcA = 0xFFFFFFFE, srcB = 3 -> busy high for 5 cycles, then hi = 0xFFFFFFFF and lo = 0xFFFFFFFA.
REQ-039 The bench SHALL cover DIV: srcA = 0xFFFFFFF9 (-7), srcB = 2 -> busy high for 10 cycles, then lo = 0xFFFFFFFD and hi = 0xFFFFFFFF.
REQ-040 The bench SHALL cover DIVU by zero with hi = 0x11, lo = 0x22 beforehand -> 10 busy cycles, then hi/lo still 0x11/0x22.
REQ-041 The bench SHALL cover MTLO srcA = 0x1234 issued during a MULT busy window -> ignored; after the MULT commits, lo equals the product's low word.
REQ-042 The bench SHALL cover reset asserted in DIV cycle 4 -> the next cycle shows busy = 0, hi = lo = 0, and no later commit.
REQ-043 The bench SHALL cover, with MDU_MADD_EN defined, hi = 0, lo = 0xFFFFFFFF, then MADDU with 1*1 -> after 5 cycles hi = 1 and lo = 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the mdop encodings, the multiply/divide latencies and the FSM state type.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU in mdu_ctrl).
package mdu_pkg;

  localparam int unsigned MDOP_W = 4;
  localparam int unsigned CNT_W  = 4;

  // Operation encodings
  localparam logic [MDOP_W-1:0] OP_MULT  = 4'd0;
  localparam logic [MDOP_W-1:0] OP_MULTU = 4'd1;
  localparam logic [MDOP_W-1:0] OP_DIV   = 4'd2;
  localparam logic [MDOP_W-1:0] OP_DIVU  = 4'd3;
  localparam logic [MDOP_W-1:0] OP_MTHI  = 4'd4;
  localparam logic [MDOP_W-1:0] OP_MTLO  = 4'd5;
  localparam logic [MDOP_W-1:0] OP_MADD  = 4'd6;
  localparam logic [MDOP_W-1:0] OP_MADDU = 4'd7;
  localparam logic [MDOP_W-1:0] OP_MSUB  = 4'd8;
  localparam logic [MDOP_W-1:0] OP_MSUBU = 4'd9;

  // Busy-window lengths in cycles
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational arithmetic for the multiply/divide unit.
// Ports:
//   op_i   - mdop selecting signedness and, with MDU_MADD_EN, accumulate mode
//   a_i    - operand A (rs)
//   b_i    - operand B (rt)
//   acc_i  - current {hi,lo}, only present with MDU_MADD_EN
//   prod_o - 64-bit product (or accumulated result)
//   quot_o - quotient, truncated toward zero
//   rem_o  - remainder, sign follows the dividend
//   dz_o   - divisor is zero
// Optional feature macro: MDU_MADD_EN.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDOP_W-1:0] op_i,
  input  logic [31:0]       a_i,
  input  logic [31:0]       b_i,
`ifdef MDU_MADD_EN
  input  logic [63:0]       acc_i,
`endif
  output logic [63:0]       prod_o,
  output logic [31:0]       quot_o,
  output logic [31:0]       rem_o,
  output logic              dz_o
);

  logic        mul_signed;
  logic [63:0] mul_res;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Multiply: sign-extend to 64 bits so the low 64 bits are the exact product
  always_comb begin
    mul_signed = (op_i == OP_MULT);
`ifdef MDU_MADD_EN
    mul_signed = mul_signed || (op_i == OP_MADD) || (op_i == OP_MSUB);
`endif
    if (mul_signed) begin
      mul_res = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    end else begin
      mul_res = {32'd0, a_i} * {32'd0, b_i};
    end
    prod_o = mul_res;
`ifdef MDU_MADD_EN
    if ((op_i == OP_MADD) || (op_i == OP_MADDU)) begin
      prod_o = acc_i + mul_res;
    end else if ((op_i == OP_MSUB) || (op_i == OP_MSUBU)) begin
      prod_o = acc_i - mul_res;
    end
`endif
  end

  // Divide on magnitudes, then restore signs; INT_MIN / -1 falls out as INT_MIN, rem 0
  always_comb begin
    div_signed = (op_i == OP_DIV);
    a_neg      = div_signed & a_i[31];
    b_neg      = div_signed & b_i[31];
    a_mag      = a_neg ? (32'd0 - a_i) : a_i;
    b_mag      = b_neg ? (32'd0 - b_i) : b_i;
    dz_o       = (b_i == 32'd0);
    // Substitute 1 for a zero divisor so the datapath never sees x/0
    b_safe     = dz_o ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot_o     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem_o      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller with HI/LO registers.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - issue strobe from E stage
//   mdop       - operation code (mdu_pkg encodings)
//   srcA, srcB - operands (rs, rt)
//   rd_hi      - read select for rdata (1 = HI, 0 = LO)
//   busy       - registered, high while a multiply/divide is in flight
//   hi, lo     - architectural HI/LO registers
//   rdata      - combinational HI/LO read mux
// Optional feature macro: MDU_MADD_EN (accepts MADD/MADDU/MSUB/MSUBU).
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MDOP_W-1:0] mdop,
  input  logic [31:0]       srcA,
  input  logic [31:0]       srcB,
  input  logic              rd_hi,
  output logic              busy,
  output logic [31:0]       hi,
  output logic [31:0]       lo,
  output logic [31:0]       rdata
);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      pend_q;
  logic             pend_wr_q;

  logic [63:0]      prod;
  logic [31:0]      quot;
  logic [31:0]      rem;
  logic             dz;

  mdu_arith u_arith (
    .op_i   (mdop),
    .a_i    (srcA),
    .b_i    (srcB),
`ifdef MDU_MADD_EN
    .acc_i  ({hi_q, lo_q}),
`endif
    .prod_o (prod),
    .quot_o (quot),
    .rem_o  (rem),
    .dz_o   (dz)
  );

  // Saturating down-counter
  assign cnt_d = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;

  // FSM, counter, pending result and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (mdop)
              OP_MULT, OP_MULTU
`ifdef MDU_MADD_EN
              , OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
`endif
              : begin
                pend_q    <= prod;
                pend_wr_q <= 1'b1;
                cnt_q     <= CNT_W'(MUL_LAT);
                busy_q    <= 1'b1;
                state_q   <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                pend_q    <= {rem, quot};
                // Divide by zero still spends the full window but commits nothing
                pend_wr_q <= ~dz;
                cnt_q     <= CNT_W'(DIV_LAT);
                busy_q    <= 1'b1;
                state_q   <= S_DIV;
              end
              OP_MTHI: hi_q <= srcA;
              OP_MTLO: lo_q <= srcA;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          // start is ignored here; only the counter advances
          cnt_q <= cnt_d;
          if (cnt_q <= CNT_W'(1)) begin
            if (pend_wr_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = rd_hi ? hi_q : lo_q;

endmodule
